move_scheduler: RTL and testbench

Arbitrates piece-movement requests (player buttons, hard drop, gravity tick) onto the single move-check/commit datapath while the main FSM is in MOVE. Issues one move operation at a time over a valid/done handshake. Reports `touched` back to the main FSM when a downward move is blocked. Sits between the input conditioning logic, the main FSM and the board/collision datapath.

---
 rtl/move_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_move_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// ---------------------------------------------------------------------------
// move_scheduler
//
// Arbitrates piece-movement requests (left, right, rotate, hard drop and the
// gravity tick) onto the single move-check/commit datapath while the main FSM
// is in MOVE. Exactly one move is in flight at a time over a valid/done
// handshake. A blocked downward move is reported back as a one-cycle
// `touched` pulse, after which the scheduler locks until `enable` drops.
//
// Parameters
//   GRAV_PERIOD  clock cycles between gravity ticks (2 .. 2**CNT_W)
//   CNT_W        gravity counter width
//
// Ports
//   i_clka        clock, all state updates on the rising edge
//   i_restart     synchronous active-high reset
//   i_enable      high while the main FSM is in MOVE
//   i_btn_left    debounced level input
//   i_btn_right   debounced level input
//   i_btn_rot     debounced level input
//   i_btn_drop    debounced level input
//   o_chk_valid   move request to the datapath
//   o_chk_op      001 LEFT, 010 RIGHT, 011 ROT, 100 DOWN, 000 idle
//   i_chk_done    one-cycle completion pulse from the datapath
//   i_chk_ok      qualifies i_chk_done: 1 committed, 0 blocked
//   o_touched     one-cycle pulse, a DOWN move was blocked
//   o_busy        high in any state other than IDLE
// ---------------------------------------------------------------------------
module move_scheduler #(
    parameter int GRAV_PERIOD = 8,
    parameter int CNT_W       = 10
) (
    input  logic       i_clka,
    input  logic       i_restart,
    input  logic       i_enable,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_rot,
    input  logic       i_btn_drop,
    output logic       o_chk_valid,
    output logic [2:0] o_chk_op,
    input  logic       i_chk_done,
    input  logic       i_chk_ok,
    output logic       o_touched,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_LOCK = 2'd3
    } state_t;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_LEFT  = 3'b001;
    localparam logic [2:0] OP_RIGHT = 3'b010;
    localparam logic [2:0] OP_ROT   = 3'b011;
    localparam logic [2:0] OP_DOWN  = 3'b100;

    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAV_PERIOD - 1);

    // Button vectors are ordered {drop, rot, right, left}.
    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_ROT   = 2;
    localparam int B_DROP  = 3;

    state_t           r_state;
    logic [3:0]       r_prev;
    logic [3:0]       r_pend;
    logic             r_grav_pend;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drop_act;
    logic             r_chk_valid;
    logic [2:0]       r_chk_op;
    logic             r_touched;

    state_t           w_state_nxt;
    logic [3:0]       w_btn;
    logic [3:0]       w_rise;
    logic             w_grav_tick;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_pend_nxt;
    logic             w_grav_nxt;
    logic             w_drop_act_nxt;
    logic             w_valid_nxt;
    logic [2:0]       w_op_nxt;
    logic             w_touched_nxt;
    logic [3:0]       w_clr;
    logic             w_clr_grav;
    logic             w_clr_all;

    // Rising edges only count while enabled, so a button held across an
    // enable transition never produces a request.
    assign w_btn       = {i_btn_drop, i_btn_rot, i_btn_right, i_btn_left};
    assign w_rise      = w_btn & ~r_prev & {4{i_enable}};
    assign w_grav_tick = i_enable && (r_cnt == GRAV_LAST);

    // Gravity counter restarts from zero every time enable rises.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!i_enable) begin
            w_cnt_nxt = '0;
        end else if (w_grav_tick) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // Next-state and registered-output logic. Pending flags are cleared
    // wholesale whenever enable is low, on a blocked DOWN and throughout LOCK;
    // otherwise a new edge on the button being served wins over its clear.
    always_comb begin
        w_state_nxt    = r_state;
        w_valid_nxt    = r_chk_valid;
        w_op_nxt       = r_chk_op;
        w_touched_nxt  = 1'b0;
        w_drop_act_nxt = r_drop_act;
        w_clr          = '0;
        w_clr_grav     = 1'b0;
        w_clr_all      = ~i_enable;

        unique case (r_state)
            ST_IDLE: begin
                if (!i_enable) begin
                    w_drop_act_nxt = 1'b0;
                end else if (r_grav_pend) begin
                    w_clr_grav  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_op_nxt    = OP_DOWN;
                    w_state_nxt = ST_REQ;
                end else if (r_pend[B_DROP]) begin
                    w_clr[B_DROP]  = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_op_nxt       = OP_DOWN;
                    w_drop_act_nxt = 1'b1;
                    w_state_nxt    = ST_REQ;
                end else if (r_pend[B_ROT]) begin
                    w_clr[B_ROT] = 1'b1;
                    w_valid_nxt  = 1'b1;
                    w_op_nxt     = OP_ROT;
                    w_state_nxt  = ST_REQ;
                end else if (r_pend[B_LEFT]) begin
                    w_clr[B_LEFT] = 1'b1;
                    w_valid_nxt   = 1'b1;
                    w_op_nxt      = OP_LEFT;
                    w_state_nxt   = ST_REQ;
                end else if (r_pend[B_RIGHT]) begin
                    w_clr[B_RIGHT] = 1'b1;
                    w_valid_nxt    = 1'b1;
                    w_op_nxt       = OP_RIGHT;
                    w_state_nxt    = ST_REQ;
                end
            end

            ST_REQ: begin
                if (i_chk_done) begin
                    w_valid_nxt = 1'b0;
                    w_op_nxt    = OP_NONE;
                    if ((r_chk_op == OP_DOWN) && !i_chk_ok) begin
                        w_touched_nxt  = 1'b1;
                        w_clr_all      = 1'b1;
                        w_drop_act_nxt = 1'b0;
                        w_state_nxt    = ST_LOCK;
                    end else if (r_drop_act && i_chk_ok && i_enable) begin
                        w_state_nxt = ST_DROP;
                    end else begin
                        w_drop_act_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end
                end
            end

            // Hard drop repeats DOWN back-to-back; the one-cycle stop here
            // provides the low gap on o_chk_valid between repeats.
            ST_DROP: begin
                w_valid_nxt = 1'b1;
                w_op_nxt    = OP_DOWN;
                w_state_nxt = ST_REQ;
            end

            ST_LOCK: begin
                w_clr_all = 1'b1;
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_pend_nxt = w_clr_all ? 4'b0000 : ((r_pend & ~w_clr) | w_rise);
        w_grav_nxt = w_clr_all ? 1'b0 : ((r_grav_pend & ~w_clr_grav) | w_grav_tick);
    end

    // State register; restart also drops any in-flight request immediately.
    always_ff @(posedge i_clka) begin
        if (i_restart) begin
            r_state     <= ST_IDLE;
            r_prev      <= '0;
            r_pend      <= '0;
            r_grav_pend <= 1'b0;
            r_cnt       <= '0;
            r_drop_act  <= 1'b0;
            r_chk_valid <= 1'b0;
            r_chk_op    <= OP_NONE;
            r_touched   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_btn;
            r_pend      <= w_pend_nxt;
            r_grav_pend <= w_grav_nxt;
            r_cnt       <= w_cnt_nxt;
            r_drop_act  <= w_drop_act_nxt;
            r_chk_valid <= w_valid_nxt;
            r_chk_op    <= w_op_nxt;
            r_touched   <= w_touched_nxt;
        end
    end

    assign o_chk_valid = r_chk_valid;
    assign o_chk_op    = r_chk_op;
    assign o_touched   = r_touched;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_move_scheduler.sv
// ---------------------------------------------------------------------------
// tb_move_scheduler
//
// Directed bench for move_scheduler with GRAV_PERIOD=8. The datapath side is
// played by hand from the stimulus sequence: each request is answered with a
// done pulse and a chosen ok value. Expected latencies and op codes below are
// worked out by hand from the scheduler's behaviour.
// ---------------------------------------------------------------------------
module tb_move_scheduler;

    logic       clka;
    logic       restart;
    logic       enable;
    logic       btnLeft;
    logic       btnRight;
    logic       btnRot;
    logic       btnDrop;
    logic       chkValid;
    logic [2:0] chkOp;
    logic       chkDone;
    logic       chkOk;
    logic       touched;
    logic       busy;

    int testsRun     = 0;
    int failCount    = 0;
    int cycleCount   = 0;
    int requestCount = 0;
    int touchCount   = 0;
    logic prevValid  = 1'b0;

    move_scheduler #(
        .GRAV_PERIOD(8),
        .CNT_W      (10)
    ) dut (
        .i_clka     (clka),
        .i_restart  (restart),
        .i_enable   (enable),
        .i_btn_left (btnLeft),
        .i_btn_right(btnRight),
        .i_btn_rot  (btnRot),
        .i_btn_drop (btnDrop),
        .o_chk_valid(chkValid),
        .o_chk_op   (chkOp),
        .i_chk_done (chkDone),
        .i_chk_ok   (chkOk),
        .o_touched  (touched),
        .o_busy     (busy)
    );

    // Free-running 10 ns clock.
    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock edge and sample 1 ns after it, tracking request
    // starts and touched pulses as they are seen.
    task automatic applyStimulus();
        @(posedge clka);
        #1;
        cycleCount++;
        if (chkValid && !prevValid) requestCount++;
        prevValid = chkValid;
        if (touched) touchCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Wait a bounded number of edges for a request to appear.
    task automatic waitValid(input string tag, input int budget);
        int n;
        n = 0;
        while (!chkValid && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_valid_seen"}, {31'd0, chkValid}, 32'd1);
    endtask

    // Act as the datapath: wait for a request, record it, then answer with a
    // done pulse `delay` cycles after valid was seen.
    task automatic serve(input string tag, input logic okVal, input int delay,
                         output logic [2:0] op, output int riseCycle);
        waitValid(tag, 40);
        op        = chkOp;
        riseCycle = cycleCount;
        repeat (delay - 1) applyStimulus();
        chkDone = 1'b1;
        chkOk   = okVal;
        applyStimulus();
        chkDone = 1'b0;
        chkOk   = 1'b0;
    endtask

    initial begin
        logic [2:0] op1, op2, op3, op4;
        int         r1, r2, r3, r4;
        int         base, reqStart, touchStart;

        restart  = 1'b1;
        enable   = 1'b0;
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        btnRot   = 1'b0;
        btnDrop  = 1'b0;
        chkDone  = 1'b0;
        chkOk    = 1'b0;

        // Reset values.
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid",   {31'd0, chkValid}, 32'd0);
        checkOutput("rst_op",      {29'd0, chkOp},    32'd0);
        checkOutput("rst_touched", {31'd0, touched},  32'd0);
        checkOutput("rst_busy",    {31'd0, busy},     32'd0);
        restart = 1'b0;

        // Enable low for 20 cycles with button activity: nothing issues.
        reqStart = requestCount;
        for (int i = 0; i < 20; i++) begin
            btnLeft = (i % 4) < 2;
            btnDrop = (i % 6) == 3;
            applyStimulus();
        end
        btnLeft = 1'b0;
        btnDrop = 1'b0;
        applyStimulus();
        checkOutput("disabled_no_req", requestCount - reqStart, 32'd0);
        checkOutput("disabled_busy",   {31'd0, busy},           32'd0);

        // Gravity: first DOWN after 9 enabled edges, then every 8.
        touchStart = touchCount;
        enable = 1'b1;
        base = cycleCount;
        serve("grav1", 1'b1, 2, op1, r1);
        serve("grav2", 1'b1, 2, op2, r2);
        serve("grav3", 1'b1, 2, op3, r3);
        checkOutput("grav_first_lat", r1 - base, 32'd9);
        checkOutput("grav_period_2",  r2 - r1,   32'd8);
        checkOutput("grav_period_3",  r3 - r2,   32'd8);
        checkOutput("grav_op1", {29'd0, op1}, 32'd4);
        checkOutput("grav_op2", {29'd0, op2}, 32'd4);
        checkOutput("grav_op3", {29'd0, op3}, 32'd4);
        checkOutput("grav_no_touch", touchCount - touchStart, 32'd0);
        enable = 1'b0;
        applyStimulus();

        // Held button: five cycles high gives a single LEFT request.
        reqStart = requestCount;
        enable  = 1'b1;
        btnLeft = 1'b1;
        applyStimulus();
        serve("held", 1'b1, 1, op1, r1);
        applyStimulus();
        applyStimulus();
        btnLeft = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("held_op",    {29'd0, op1},            32'd1);
        checkOutput("held_count", requestCount - reqStart, 32'd1);
        enable = 1'b0;
        applyStimulus();

        // Simultaneous left/right/rot: served ROT, LEFT, RIGHT with gaps.
        enable   = 1'b1;
        btnLeft  = 1'b1;
        btnRight = 1'b1;
        btnRot   = 1'b1;
        applyStimulus();
        serve("sim1", 1'b1, 1, op1, r1);
        serve("sim2", 1'b1, 1, op2, r2);
        serve("sim3", 1'b1, 1, op3, r3);
        checkOutput("sim_op1", {29'd0, op1}, 32'd3);
        checkOutput("sim_op2", {29'd0, op2}, 32'd1);
        checkOutput("sim_op3", {29'd0, op3}, 32'd2);
        checkOutput("sim_gap2", r2 - r1, 32'd2);
        checkOutput("sim_gap3", r3 - r2, 32'd2);
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        btnRot   = 1'b0;
        enable   = 1'b0;
        applyStimulus();

        // Hard drop: three legal DOWNs then a blocked one, then LOCK.
        touchStart = touchCount;
        enable  = 1'b1;
        btnDrop = 1'b1;
        applyStimulus();
        serve("drop1", 1'b1, 1, op1, r1);
        serve("drop2", 1'b1, 1, op2, r2);
        serve("drop3", 1'b1, 1, op3, r3);
        serve("drop4", 1'b0, 1, op4, r4);
        checkOutput("drop_touched_now", {31'd0, touched},  32'd1);
        checkOutput("drop_valid_low",   {31'd0, chkValid}, 32'd0);
        checkOutput("drop_op1", {29'd0, op1}, 32'd4);
        checkOutput("drop_op2", {29'd0, op2}, 32'd4);
        checkOutput("drop_op3", {29'd0, op3}, 32'd4);
        checkOutput("drop_op4", {29'd0, op4}, 32'd4);
        checkOutput("drop_gap2", r2 - r1, 32'd2);
        checkOutput("drop_gap3", r3 - r2, 32'd2);
        checkOutput("drop_gap4", r4 - r3, 32'd2);
        btnDrop = 1'b0;
        applyStimulus();
        checkOutput("drop_touched_pulse", {31'd0, touched},      32'd0);
        checkOutput("drop_touch_count",   touchCount - touchStart, 32'd1);
        reqStart = requestCount;
        for (int i = 0; i < 20; i++) begin
            btnLeft = (i % 4) == 1;
            btnRot  = (i % 5) == 2;
            applyStimulus();
        end
        btnLeft = 1'b0;
        btnRot  = 1'b0;
        applyStimulus();
        checkOutput("lock_no_req", requestCount - reqStart, 32'd0);
        checkOutput("lock_busy",   {31'd0, busy},           32'd1);
        enable = 1'b0;
        applyStimulus();
        checkOutput("lock_exit_busy", {31'd0, busy}, 32'd0);
        enable  = 1'b1;
        btnLeft = 1'b1;
        applyStimulus();
        serve("relock", 1'b1, 1, op1, r1);
        checkOutput("relock_op", {29'd0, op1}, 32'd1);
        btnLeft = 1'b0;
        enable  = 1'b0;
        applyStimulus();

        // Blocked gravity with a rot edge pending: rot is discarded.
        enable = 1'b1;
        base = cycleCount;
        waitValid("bgrav", 40);
        checkOutput("bgrav_lat", cycleCount - base, 32'd9);
        checkOutput("bgrav_op",  {29'd0, chkOp},    32'd4);
        btnRot = 1'b1;
        applyStimulus();
        chkDone = 1'b1;
        chkOk   = 1'b0;
        applyStimulus();
        chkDone = 1'b0;
        btnRot  = 1'b0;
        checkOutput("bgrav_touched", {31'd0, touched}, 32'd1);
        applyStimulus();
        checkOutput("bgrav_touched_end", {31'd0, touched}, 32'd0);
        reqStart = requestCount;
        repeat (6) applyStimulus();
        checkOutput("bgrav_busy",   {31'd0, busy},           32'd1);
        checkOutput("bgrav_no_req", requestCount - reqStart, 32'd0);
        enable = 1'b0;
        applyStimulus();
        checkOutput("bgrav_exit_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        repeat (6) applyStimulus();
        checkOutput("bgrav_rot_dropped", requestCount - reqStart, 32'd0);
        enable = 1'b0;
        applyStimulus();

        // Restart while a request is in flight drops everything on one edge.
        enable   = 1'b1;
        btnRight = 1'b1;
        applyStimulus();
        waitValid("rstreq", 10);
        checkOutput("rstreq_op", {29'd0, chkOp}, 32'd2);
        btnRight = 1'b0;
        restart  = 1'b1;
        applyStimulus();
        checkOutput("rstreq_valid",   {31'd0, chkValid}, 32'd0);
        checkOutput("rstreq_op0",     {29'd0, chkOp},    32'd0);
        checkOutput("rstreq_touched", {31'd0, touched},  32'd0);
        checkOutput("rstreq_busy",    {31'd0, busy},     32'd0);
        restart = 1'b0;
        enable  = 1'b0;
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
